// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch requester
//   (inst_*) and the EXE-stage data requester (data_*). Address-phase requests
//   are arbitrated and the owner of every accepted request is recorded in an
//   in-order owner FIFO; each returning mem_data_ok/mem_rdata is routed back to
//   the owner at the FIFO head.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     inst_* / data_*       requester SRAM-like ports (req/wr/size/addr/wstrb/
//                           wdata in; addr_ok/data_ok/rdata out)
//     mem_*                 downstream SRAM-like port (req/wr/size/addr/wstrb/
//                           wdata out; addr_ok/data_ok/rdata in)
//     outst_cnt             accepted-but-unreturned transaction count
//     err_spurious          sticky flag: mem_data_ok seen with FIFO empty
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> IDLE ties alternate between requesters (data wins first tie)
//     undefined -> fixed data-over-inst priority
module sram_like_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int OUTST_W     = 3
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               inst_req,
    input  logic               inst_wr,
    input  logic [1:0]         inst_size,
    input  logic [31:0]        inst_addr,
    input  logic [3:0]         inst_wstrb,
    input  logic [31:0]        inst_wdata,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [31:0]        inst_rdata,

    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [31:0]        data_addr,
    input  logic [3:0]         data_wstrb,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,

    output logic               mem_req,
    output logic               mem_wr,
    output logic [1:0]         mem_size,
    output logic [31:0]        mem_addr,
    output logic [3:0]         mem_wstrb,
    output logic [31:0]        mem_wdata,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [31:0]        mem_rdata,

    output logic [OUTST_W-1:0] outst_cnt,
    output logic               err_spurious
);

    localparam int PTR_W = OUTST_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t                 state;
    logic [OUTST_DEPTH-1:0] owner_fifo;   // 0 = inst, 1 = data
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_grant;   // 0 = inst served last, 1 = data
`endif

    logic cand_valid;
    logic cand_data;
    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic head;

    assign full  = (outst_cnt == OUTST_W'(OUTST_DEPTH));
    assign empty = (outst_cnt == '0);
    assign head  = owner_fifo[rd_ptr];

    // Candidate selection; reset masks the candidate so every forwarded
    // output is quiet during the reset cycle.
    always_comb begin
        cand_valid = 1'b0;
        cand_data  = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && inst_req) begin
                    cand_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    cand_data  = ~last_grant;
`else
                    cand_data  = 1'b1;
`endif
                end else if (data_req) begin
                    cand_valid = 1'b1;
                    cand_data  = 1'b1;
                end else if (inst_req) begin
                    cand_valid = 1'b1;
                end
            end
            HOLD_I: cand_valid = inst_req;
            HOLD_D: begin
                cand_valid = data_req;
                cand_data  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            cand_valid = 1'b0;
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (cand_valid) begin
            mem_wr    = cand_data ? data_wr    : inst_wr;
            mem_size  = cand_data ? data_size  : inst_size;
            mem_addr  = cand_data ? data_addr  : inst_addr;
            mem_wstrb = cand_data ? data_wstrb : inst_wstrb;
            mem_wdata = cand_data ? data_wdata : inst_wdata;
        end
    end

    // Full blocks forwarding even if a pop happens this cycle (no bypass).
    assign mem_req      = cand_valid & ~full;
    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~cand_data;
    assign data_addr_ok = accept &  cand_data;

    assign pop          = mem_data_ok & ~empty & ~reset;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop &  head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outst_cnt    <= '0;
            err_spurious <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state <= IDLE;
            end else if (cand_valid) begin
                state <= cand_data ? HOLD_D : HOLD_I;
            end else begin
                state <= IDLE;
            end

            if (accept) begin
                owner_fifo[wr_ptr] <= cand_data;
                wr_ptr             <= wr_ptr + 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant         <= cand_data;
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({accept, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: ;
            endcase

            if (mem_data_ok && empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Randomized and directed stimulus for sram_like_arbiter. A behavioural model
//   (owner queue, locked-owner and last-served variables) produces per-cycle
//   expectations and expected responses into queues; monitor processes pop and
//   compare them against the DUT on the falling clock edge.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_spurious;

    sram_like_arbiter #(.OUTST_DEPTH(4), .OUTST_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          chk_state;
        logic        mem_req;
        txn_t        fwd;
        logic        iao, dao, ido, ddo;
        logic [31:0] rdata;
        int          cnt;
        logic        err;
    } exp_t;

    typedef struct {
        bit          owner_data;
        logic [31:0] rdata;
    } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state
    bit   oq[$];            // owners of accepted, unreturned requests (1 = data)
    int   lock = 0;         // 0 none, 1 inst, 2 data: owner shown but not yet accepted
    bit   m_last_data = 0;  // last served requester was data
    bit   m_err = 0;
    bit   pend_i = 0, pend_d = 0;
    txn_t ti, td;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = 2'($urandom_range(0, 2));
        t.addr  = $urandom;
        t.wstrb = 4'($urandom);
        t.wdata = $urandom;
        return t;
    endfunction

    // One cycle of stimulus: drive inputs, derive expectations from the model,
    // advance the model, then move to just after the next rising edge.
    task automatic step(input bit rst, input bit ni, input bit nd,
                        input bit aok, input bit dok, input bit chk_state = 1'b1);
        exp_t        e;
        logic [31:0] rd;
        int          cand;
        bit          acc, pp;
        if (!rst) begin
            if (ni && !pend_i) begin pend_i = 1; ti = rand_txn(); end
            if (nd && !pend_d) begin pend_d = 1; td = rand_txn(); end
        end
        rd          = $urandom;
        reset       = rst;
        inst_req    = pend_i;
        inst_wr     = ti.wr;   inst_size = ti.size; inst_addr = ti.addr;
        inst_wstrb  = ti.wstrb; inst_wdata = ti.wdata;
        data_req    = pend_d;
        data_wr     = td.wr;   data_size = td.size; data_addr = td.addr;
        data_wstrb  = td.wstrb; data_wdata = td.wdata;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;

        e.chk_state = chk_state;
        e.mem_req   = 0;
        e.fwd       = '{wr: 0, size: 0, addr: 0, wstrb: 0, wdata: 0};
        e.iao = 0; e.dao = 0; e.ido = 0; e.ddo = 0;
        e.rdata     = rd;
        e.cnt       = oq.size();
        e.err       = m_err;

        if (rst) begin
            exp_q.push_back(e);
            oq.delete();
            lock = 0; m_last_data = 0; m_err = 0; pend_i = 0; pend_d = 0;
        end else begin
            cand = 0;
            if (lock == 1)      cand = pend_i ? 1 : 0;
            else if (lock == 2) cand = pend_d ? 2 : 0;
            else if (pend_i && pend_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                cand = m_last_data ? 1 : 2;
`else
                cand = 2;
`endif
            end
            else if (pend_d) cand = 2;
            else if (pend_i) cand = 1;

            if (cand == 1) e.fwd = ti;
            if (cand == 2) e.fwd = td;
            e.mem_req = (cand != 0) && (oq.size() < DEPTH);
            acc   = e.mem_req && aok;
            e.iao = acc && cand == 1;
            e.dao = acc && cand == 2;
            pp    = dok && oq.size() > 0;
            if (pp) begin
                e.ido = !oq[0];
                e.ddo = oq[0];
                resp_q.push_back('{owner_data: oq[0], rdata: rd});
            end
            exp_q.push_back(e);

            if (dok && oq.size() == 0) m_err = 1;
            if (pp) void'(oq.pop_front());
            if (acc) begin
                oq.push_back(cand == 2);
                m_last_data = (cand == 2);
                if (cand == 1) pend_i = 0; else pend_d = 0;
                lock = 0;
            end else begin
                lock = cand;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mem_req",      32'(mem_req),      32'(e.mem_req));
            chk("mem_wr",       32'(mem_wr),       32'(e.fwd.wr));
            chk("mem_size",     32'(mem_size),     32'(e.fwd.size));
            chk("mem_addr",     mem_addr,          e.fwd.addr);
            chk("mem_wstrb",    32'(mem_wstrb),    32'(e.fwd.wstrb));
            chk("mem_wdata",    mem_wdata,         e.fwd.wdata);
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e.iao));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(e.dao));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(e.ido));
            chk("data_data_ok", 32'(data_data_ok), 32'(e.ddo));
            chk("inst_rdata",   inst_rdata,        e.rdata);
            chk("data_rdata",   data_rdata,        e.rdata);
            if (e.chk_state) begin
                chk("outst_cnt",    32'(outst_cnt),    32'(e.cnt));
                chk("err_spurious", 32'(err_spurious), 32'(e.err));
            end
        end
    end

    // Response scoreboard: every routed response must match the next expected one
    always @(negedge clk) begin
        if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 32'(1), 32'(0));
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("resp_owner", 32'(data_data_ok), 32'(r.owner_data));
                chk("resp_rdata", r.owner_data ? data_rdata : inst_rdata, r.rdata);
            end
        end
    end

    initial begin
        reset = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        mem_rdata = 0;
        ti = '{wr: 0, size: 0, addr: 0, wstrb: 0, wdata: 0};
        td = ti;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0,
                 oq.size() > 0 && $urandom_range(0, 2) != 0);
        end

        // Drain everything
        for (int i = 0; i < 100 && (oq.size() > 0 || pend_i || pend_d); i++)
            step(0, 0, 0, 1, oq.size() > 0);

        // Stall on slave with inst held, data rising later: inst stays locked
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 10 && oq.size() > 0; i++) step(0, 0, 0, 0, 1);

        // Fill the FIFO, block the 5th, release with a single pop
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // Reset with transactions outstanding, then a stray response
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);

        // Both requesters continuously asking
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, oq.size() > 0);
        for (int i = 0; i < 20 && (oq.size() > 0 || pend_i || pend_d); i++)
            step(0, 0, 0, 1, oq.size() > 0);

        @(negedge clk);
        #1;
        chk("exp_queue_drained",  32'(exp_q.size()),  32'(0));
        chk("resp_queue_drained", 32'(resp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst_*) and the EXE-stage data requester (data_*).
- Arbitrates address-phase requests and records the owner of every accepted request in an in-order owner FIFO.
- Routes each returning data_ok/rdata to the correct requester.
- Sits between the pipeline's inst/data SRAM-like ports and the downstream bridge/memory.

Parameters:
- OUTST_DEPTH, 4, max accepted-but-unreturned transactions (power of 2, >=2)
- OUTST_W, 3, width of outst_cnt; equals log2(OUTST_DEPTH)+1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_req / inst_wr  in  1/1  inst request valid / write
- inst_size  in  2  0:1B 1:2B 2:4B
- inst_addr / inst_wdata  in  32/32  address / write data
- inst_wstrb  in  4  byte write strobes
- inst_addr_ok / inst_data_ok  out  1/1  inst address accepted / response valid
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and directions as the inst_* group
- mem_req, mem_wr  out  1/1  forwarded request / write
- mem_size  out  2  forwarded size
- mem_addr, mem_wdata  out  32/32  forwarded address / write data
- mem_wstrb  out  4  forwarded strobes
- mem_addr_ok, mem_data_ok  in  1/1  slave accept / response
- mem_rdata  in  32  slave read data
- outst_cnt  out  OUTST_W  current FIFO occupancy
- err_spurious  out  1  sticky: mem_data_ok arrived with FIFO empty

Behaviour:
- One clock; reset is synchronous and active-high on clk/reset.
- Reset clears:
  - grant state to IDLE
  - FIFO pointers and count (outst_cnt=0)
  - err_spurious=0
- During the reset cycle all combinational outputs (mem_req, *_addr_ok, *_data_ok) are forced 0.
- Grant FSM states: IDLE, HOLD_I, HOLD_D.
  - IDLE: candidate is data when data_req=1, else inst when inst_req=1, else none. Data has fixed priority.
  - HOLD_I / HOLD_D: candidate is locked to inst / data regardless of the other req.
- Forwarding:
  - mem_req = candidate_req & ~full, where full means outst_cnt==OUTST_DEPTH.
  - Full blocks forwarding even when a pop occurs in the same cycle. There is no bypass.
  - mem_wr/size/addr/wstrb/wdata are muxed from the candidate. When there is no candidate these outputs are 0.
- Acceptance = mem_req & mem_addr_ok. On acceptance:
  - candidate's *_addr_ok=1 in the same cycle (combinational); the other requester sees addr_ok=0.
  - owner bit (0=inst, 1=data) is pushed into the FIFO.
  - FSM goes to IDLE.
- Transitions:
  - candidate req=1 without acceptance (slave stall or full) -> HOLD of that owner.
  - HOLD stays until acceptance.
  - candidate req dropping while in HOLD -> IDLE. Requesters must not do this; the arbiter tolerates it.
- Response:
  - mem_data_ok with FIFO non-empty pops the head.
  - head owner's *_data_ok=1 same cycle, and its *_rdata=mem_rdata.
  - the other requester's data_ok=0; both rdata buses carry mem_rdata.
  - Write responses are routed identically.
- Simultaneous push and pop: count unchanged, both pointers advance. Wrap-around is modulo OUTST_DEPTH.
- mem_data_ok with FIFO empty: no pop, no *_data_ok, err_spurious set to 1 next cycle and held until reset.
- Latency:
  - addr path 0 cycles (combinational pass-through).
  - data_ok routing 0 cycles.
  - Responses are returned strictly in acceptance order.
- Reset mid-transaction discards all outstanding owners. Later mem_data_ok for those transactions raises err_spurious; the system flushes the slave together with the arbiter.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE candidate selection alternates. A 1-bit last_grant register is updated on each acceptance; when both req=1, the requester not served last wins.
  - last_grant resets to inst, so data wins the first tie.
- Undefined: fixed data-over-inst priority as above; no last_grant register.

Test Plan:
- inst_req=1, data_req=1 same cycle, mem_addr_ok=1 -> data_addr_ok=1 and mem_addr=data_addr in cycle 0. inst accepted in cycle 1. FIFO holds {data,inst}.
- inst_req=1 at 0x1C000000 with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays 0x1C000000 (HOLD_I). inst accepted on cycle 3, data on cycle 4.
- Issue 4 accepted inst reads with no mem_data_ok -> outst_cnt=4 and mem_req=0 while a 5th req is pending. One mem_data_ok -> outst_cnt=3; 5th req forwarded the next cycle.
- Accept data, inst, data; return mem_data_ok with rdata 0xA,0xB,0xC -> data_data_ok/0xA, inst_data_ok/0xB, data_data_ok/0xC in order. outst_cnt returns to 0.
- Assert reset with outst_cnt=2 -> outst_cnt=0, mem_req=0. A following mem_data_ok -> err_spurious=1 one cycle later and it stays 1.
- With ARB_ROUND_ROBIN_EN, both reqs held high, mem_addr_ok=1 -> accepted order data, inst, data, inst.
